// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial word feeder for the sequence detector: valid/ready word intake,
// one-word holding register, one registered payload bit per clock with optional inter-word gap.
module serial_bit_feeder #(
    parameter int   WIDTH      = 8,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_LEVEL = 1'b0,
    parameter int   GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             data_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int         CNT_W   = $clog2(WIDTH);
    localparam bit         L_MSB   = (MSB_FIRST != 0);
    localparam bit         HAS_GAP = (GAP_CYCLES != 0);
    localparam logic [3:0] GAP_LD  = 4'(GAP_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_sh;
    logic [WIDTH-1:0]   r_hold;
    logic               r_hold_full;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_gcnt;
    logic               r_data_out;
    logic               r_bit_valid;
    logic               r_word_done;

    logic               w_xfer;
    logic               w_last;
    logic               w_gap_end;
    logic               w_slot;
    logic               w_load_hold;
    logic               w_load_in;
    logic               w_load;
    logic               w_hold_wr;
    logic [WIDTH-1:0]   w_load_word;
    logic               w_first;
    logic [WIDTH-1:0]   w_rest;

    assign w_xfer      = word_valid & ~r_hold_full;
    assign w_last      = (r_state == S_SHIFT) && (r_cnt == '0);
    assign w_gap_end   = (r_state == S_GAP) && (r_gcnt == 4'd1);
    // A new word may enter sh: from idle, right after a last bit (no gap), or at gap end.
    assign w_slot      = (r_state == S_IDLE) | (w_last & ~HAS_GAP) | w_gap_end;
    assign w_load_hold = w_slot & r_hold_full;
    assign w_load_in   = w_slot & ~r_hold_full & w_xfer;
    assign w_load      = w_load_hold | w_load_in;
    assign w_hold_wr   = w_xfer & ~w_load_in;
    assign w_load_word = r_hold_full ? r_hold : word_in;
    assign w_first     = L_MSB ? w_load_word[WIDTH-1] : w_load_word[0];
    assign w_rest      = L_MSB ? (w_load_word << 1) : (w_load_word >> 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sh        <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_cnt       <= '0;
            r_gcnt      <= '0;
            r_data_out  <= IDLE_LEVEL;
            r_bit_valid <= 1'b0;
            r_word_done <= 1'b0;
        end else begin
            if (w_hold_wr) begin
                r_hold      <= word_in;
                r_hold_full <= 1'b1;
            end else if (w_load_hold) begin
                r_hold_full <= 1'b0;
            end

            if (w_load) begin
                r_state     <= S_SHIFT;
                r_sh        <= w_rest;
                r_cnt       <= CNT_W'(WIDTH - 1);
                r_data_out  <= w_first;
                r_bit_valid <= 1'b1;
                r_word_done <= 1'b0;
            end else begin
                case (r_state)
                    S_SHIFT: begin
                        if (r_cnt != '0) begin
                            r_data_out  <= L_MSB ? r_sh[WIDTH-1] : r_sh[0];
                            r_sh        <= L_MSB ? (r_sh << 1) : (r_sh >> 1);
                            r_cnt       <= r_cnt - CNT_W'(1);
                            r_word_done <= (r_cnt == CNT_W'(1));
                        end else begin
                            r_data_out  <= IDLE_LEVEL;
                            r_bit_valid <= 1'b0;
                            r_word_done <= 1'b0;
                            if (HAS_GAP) begin
                                r_state <= S_GAP;
                                r_gcnt  <= GAP_LD;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    S_GAP: begin
                        r_gcnt <= r_gcnt - 4'd1;
                        if (r_gcnt == 4'd1) r_state <= S_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign word_ready = ~r_hold_full;
    assign data_out   = r_data_out;
    assign bit_valid  = r_bit_valid;
    assign word_done  = r_word_done;
    assign busy       = (r_state != S_IDLE) | r_hold_full;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: three configurations checked each cycle against a
// word-schedule model, plus literal bit streams for the directed cases.
module tb_serial_bit_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] word_in[3]    = '{8'h00, 8'h00, 8'h00};
    logic       word_valid[3] = '{1'b0, 1'b0, 1'b0};
    logic       word_ready[3];
    logic       data_out[3];
    logic       bit_valid[3];
    logic       word_done[3];
    logic       busy[3];

    // u0: default, u1: 2-cycle gap with idle level 1, u2: LSB first
    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0), .GAP_CYCLES(0)) u0 (
        .clk(clk), .reset(rst), .word_in(word_in[0]), .word_valid(word_valid[0]),
        .word_ready(word_ready[0]), .data_out(data_out[0]), .bit_valid(bit_valid[0]),
        .word_done(word_done[0]), .busy(busy[0]));
    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b1), .GAP_CYCLES(2)) u1 (
        .clk(clk), .reset(rst), .word_in(word_in[1]), .word_valid(word_valid[1]),
        .word_ready(word_ready[1]), .data_out(data_out[1]), .bit_valid(bit_valid[1]),
        .word_done(word_done[1]), .busy(busy[1]));
    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b0), .GAP_CYCLES(0)) u2 (
        .clk(clk), .reset(rst), .word_in(word_in[2]), .word_valid(word_valid[2]),
        .word_ready(word_ready[2]), .data_out(data_out[2]), .bit_valid(bit_valid[2]),
        .word_done(word_done[2]), .busy(busy[2]));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // model: every accepted word gets a start cycle; its bits occupy start..start+7
    int         m_s[3][128];
    logic [7:0] m_w[3][128];
    int         m_n[3]    = '{0, 0, 0};
    int         m_last[3] = '{-1000, -1000, -1000};
    int         st_m;

    logic [7:0] src[3][64];
    int         s_head[3] = '{0, 0, 0};
    int         s_tail[3] = '{0, 0, 0};

    logic dcap[3][64];
    logic mcap[3][64];
    int   dcyc[3][64];
    int   mcyc[3][64];
    int   dn[3], mn[3], dr[3], mr[3], dwd[3];

    logic e_bv, e_do, e_wd, e_rdy, e_busy;
    int   e_s, e_idx;
    logic [7:0] e_w;

    function automatic int gap_of(input int i);
        return (i == 1) ? 2 : 0;
    endfunction
    function automatic bit msb_of(input int i);
        return (i != 2);
    endfunction
    function automatic logic idl_of(input int i);
        return (i == 1) ? 1'b1 : 1'b0;
    endfunction

    function automatic bit m_pending(input int i, input int k);
        for (int j = 0; j < m_n[i]; j++) if (m_s[i][j] >= k) return 1'b1;
        return 1'b0;
    endfunction
    function automatic bit m_busy(input int i, input int k);
        for (int j = 0; j < m_n[i]; j++) if (m_s[i][j] + 7 + gap_of(i) >= k) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // acceptance happens at an edge when no accepted word is still waiting to start
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_n[i]    = 0;
                m_last[i] = -1000;
            end else if (word_valid[i] === 1'b1 && !m_pending(i, cyc) && m_n[i] < 128) begin
                st_m = m_last[i] + 8 + gap_of(i);
                if (st_m < cyc) st_m = cyc;
                m_s[i][m_n[i]] = st_m;
                m_w[i][m_n[i]] = word_in[i];
                m_n[i]++;
                m_last[i] = st_m;
                s_head[i]++;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst && s_head[i] < s_tail[i]) begin
                word_valid[i] = 1'b1;
                word_in[i]    = src[i][s_head[i]];
            end else begin
                word_valid[i] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            e_bv = 1'b0; e_do = idl_of(i); e_wd = 1'b0; e_rdy = 1'b1; e_busy = 1'b0;
            if (!rst) begin
                for (int j = 0; j < m_n[i]; j++) begin
                    e_s = m_s[i][j];
                    if (e_s > cyc) begin
                        e_rdy = 1'b0;
                        e_busy = 1'b1;
                    end
                    if (cyc >= e_s && cyc <= e_s + 7) begin
                        e_bv  = 1'b1;
                        e_idx = cyc - e_s;
                        e_w   = m_w[i][j];
                        e_do  = msb_of(i) ? e_w[7 - e_idx] : e_w[e_idx];
                        e_wd  = (e_idx == 7);
                    end
                    if (cyc >= e_s && cyc <= e_s + 7 + gap_of(i)) e_busy = 1'b1;
                end
            end
            chk($sformatf("u%0d bit_valid c%0d", i, cyc), 32'(bit_valid[i]), 32'(e_bv));
            chk($sformatf("u%0d data_out c%0d", i, cyc), 32'(data_out[i]), 32'(e_do));
            chk($sformatf("u%0d word_done c%0d", i, cyc), 32'(word_done[i]), 32'(e_wd));
            chk($sformatf("u%0d word_ready c%0d", i, cyc), 32'(word_ready[i]), 32'(e_rdy));
            chk($sformatf("u%0d busy c%0d", i, cyc), 32'(busy[i]), 32'(e_busy));
            if (bit_valid[i] === 1'b1 && dn[i] < 64) begin
                dcap[i][dn[i]] = data_out[i];
                dcyc[i][dn[i]] = cyc;
                dn[i]++;
            end
            if (e_bv && mn[i] < 64) begin
                mcap[i][mn[i]] = e_do;
                mcyc[i][mn[i]] = cyc;
                mn[i]++;
            end
            if (word_ready[i] !== 1'b1) dr[i]++;
            if (!e_rdy) mr[i]++;
            if (word_done[i] === 1'b1) dwd[i]++;
        end
    end

    task automatic clear_cap(input int i);
        dn[i] = 0; mn[i] = 0; dr[i] = 0; mr[i] = 0; dwd[i] = 0;
    endtask

    task automatic push(input int i, input logic [7:0] w);
        src[i][s_tail[i]] = w;
        s_tail[i]++;
    endtask

    task automatic wait_idle(input int i, input string nm);
        bit done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            #1;
            if (s_head[i] == s_tail[i] && !m_busy(i, cyc)) done = 1'b1;
        end
        chk({nm, " idle_within_budget"}, 32'(done), 32'd1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic check_stream(input int i, input logic [31:0] exp, input int n, input string nm);
        logic [31:0] dv = '0;
        logic [31:0] mv = '0;
        chk({nm, " dut_bit_count"}, 32'(dn[i]), 32'(n));
        chk({nm, " model_bit_count"}, 32'(mn[i]), 32'(n));
        for (int b = 0; b < n; b++) begin
            if (b < dn[i]) dv[n - 1 - b] = dcap[i][b];
            if (b < mn[i]) mv[n - 1 - b] = mcap[i][b];
        end
        chk({nm, " dut_bits"}, dv, exp);
        chk({nm, " model_bits"}, mv, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    int s0;
    bit ok;

    initial begin
        for (int i = 0; i < 3; i++) clear_cap(i);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("reset word_ready", 32'(word_ready[0]), 32'd1);
        chk("reset busy", 32'(busy[0]), 32'd0);
        chk("reset bit_valid", 32'(bit_valid[0]), 32'd0);
        chk("reset idle_level_1", 32'(data_out[1]), 32'd1);

        // single word, MSB first
        clear_cap(0);
        push(0, 8'hEC);
        wait_idle(0, "t1");
        check_stream(0, 32'hEC, 8, "t1");
        chk("t1 word_done_pulses", 32'(dwd[0]), 32'd1);
        chk("t1 done_on_last_bit", 32'(dcyc[0][7] - dcyc[0][0]), 32'd7);

        // back-to-back through the holding register
        clear_cap(0);
        push(0, 8'hEC);
        push(0, 8'h3B);
        wait_idle(0, "t2");
        check_stream(0, 32'hEC3B, 16, "t2");
        chk("t2 no_bubble", 32'(dcyc[0][15] - dcyc[0][0]), 32'd15);
        chk("t2 dut_ready_low", 32'(dr[0]), 32'd7);
        chk("t2 model_ready_low", 32'(mr[0]), 32'd7);
        chk("t2 word_done_pulses", 32'(dwd[0]), 32'd2);

        // backpressure on the third word
        clear_cap(0);
        push(0, 8'hEC);
        push(0, 8'h3B);
        push(0, 8'hA5);
        wait_idle(0, "t3");
        check_stream(0, 32'hEC3BA5, 24, "t3");
        chk("t3 no_bubble", 32'(dcyc[0][23] - dcyc[0][0]), 32'd23);
        chk("t3 dut_ready_low", 32'(dr[0]), 32'd14);
        chk("t3 model_ready_low", 32'(mr[0]), 32'd14);

        // two-cycle gap between words
        clear_cap(1);
        push(1, 8'hEC);
        push(1, 8'h3B);
        wait_idle(1, "t4");
        check_stream(1, 32'hEC3B, 16, "t4");
        chk("t4 dut_gap", 32'(dcyc[1][8] - dcyc[1][7] - 1), 32'd2);
        chk("t4 model_gap", 32'(mcyc[1][8] - mcyc[1][7] - 1), 32'd2);

        // LSB first
        clear_cap(2);
        push(2, 8'h37);
        wait_idle(2, "t5");
        check_stream(2, 32'hEC, 8, "t5");

        // reset on the 4th bit with hold full
        clear_cap(0);
        push(0, 8'hEC);
        push(0, 8'h3B);
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (s_head[0] == s_tail[0] && m_n[0] >= 2) begin
                s0 = m_s[0][m_n[0] - 2];
                if (cyc >= s0 + 3) ok = 1'b1;
            end
        end
        chk("t6 reached_4th_bit", 32'(ok), 32'd1);
        chk("t6 4th_bit_value", 32'(data_out[0]), 32'd0);
        chk("t6 4th_bit_valid", 32'(bit_valid[0]), 32'd1);
        chk("t6 hold_full", 32'(word_ready[0]), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("t6 rst bit_valid", 32'(bit_valid[0]), 32'd0);
        chk("t6 rst data_out", 32'(data_out[0]), 32'd0);
        chk("t6 rst word_done", 32'(word_done[0]), 32'd0);
        chk("t6 rst busy", 32'(busy[0]), 32'd0);
        chk("t6 rst word_ready", 32'(word_ready[0]), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        #1;
        clear_cap(0);
        push(0, 8'hA5);
        wait_idle(0, "t6");
        check_stream(0, 32'hA5, 8, "t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
